fft_out_reorder: RTL

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

---
 rtl/fft_out_reorder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/fft_out_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fft_out_reorder: ping-pong transpose buffer, row-major sub-FFT output in,
// natural (column-major) order out. Rev 1.0
// ============================================================================
module fft_out_reorder #(
  parameter int WIDTH  = 18,
  parameter int N1_MAX = 16,
  parameter int N2_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       n1,
  input  logic [7:0]       n2,
  input  logic             cfg_load,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             out_last,
  output logic             busy
);
  localparam int         DEPTH  = N1_MAX * N2_MAX;
  localparam int         AW     = $clog2(2 * DEPTH);
  localparam logic [8:0] N1_LIM = 9'(N1_MAX);
  localparam logic [7:0] N2_LIM = 8'(N2_MAX);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  bank_state_t      bank_q [2];
  bank_state_t      bank_d [2];
  logic [8:0]       n1_q, n1_d;
  logic [7:0]       n2_q, n2_d;
  logic             cfg_err_q, cfg_err_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [8:0]       wr_r_q, wr_r_d;
  logic [7:0]       wr_c_q, wr_c_d;
  logic             iss_ptr_q, iss_ptr_d;
  logic             iss_act_q, iss_act_d;
  logic [8:0]       iss_r_q, iss_r_d;
  logic [7:0]       iss_c_q, iss_c_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_last_q, s1_last_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_re_q, out_re_d;
  logic [WIDTH-1:0] out_im_q, out_im_d;
  logic [WIDTH-1:0] rd_re_q, rd_im_q;

  logic [WIDTH-1:0] mem_re [2*DEPTH];
  logic [WIDTH-1:0] mem_im [2*DEPTH];

  logic          wr_fire, wr_last, rd_en, iss_last, s2_load, out_fire, drain_done;
  logic [AW-1:0] wr_addr, rd_addr;

  function automatic logic [AW-1:0] addr_of(input logic bank, input logic [8:0] r,
                                            input logic [7:0] c);
    logic [AW-1:0] base;
    base = bank ? AW'(DEPTH) : '0;
    return base + AW'(r) * AW'(N2_MAX) + AW'(c);
  endfunction

  assign busy       = (bank_q[0] != EMPTY) || (bank_q[1] != EMPTY);
  assign in_ready   = (bank_q[wr_ptr_q] == EMPTY) || (bank_q[wr_ptr_q] == FILLING);
  assign wr_fire    = in_valid && in_ready;
  assign wr_last    = (wr_r_q == n1_q - 9'd1) && (wr_c_q == n2_q - 8'd1);
  assign iss_last   = (iss_r_q == n1_q - 9'd1) && (iss_c_q == n2_q - 8'd1);
  // Stage 2 (output register) can take a word when empty or being consumed;
  // a RAM read is issued only if stage 1 will have room for its result.
  assign s2_load    = !out_valid_q || out_ready;
  assign rd_en      = (iss_act_q || (bank_q[iss_ptr_q] == FULL)) && (!s1_valid_q || s2_load);
  assign out_fire   = out_valid_q && out_ready;
  assign drain_done = out_fire && out_last_q;
  assign wr_addr    = addr_of(wr_ptr_q, wr_r_q, wr_c_q);
  assign rd_addr    = addr_of(iss_ptr_q, iss_r_q, iss_c_q);

  always_comb begin
    n1_d      = n1_q;
    n2_d      = n2_q;
    cfg_err_d = 1'b0;
    if (cfg_load) begin
      if (busy || (n1 == 9'd0) || (n1 > N1_LIM) || (n2 == 8'd0) || (n2 > N2_LIM)) begin
        cfg_err_d = 1'b1;
      end else begin
        n1_d = n1;
        n2_d = n2;
      end
    end
  end

  // Write, issue and drain always touch distinct banks, so the updates never collide.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      if (wr_fire && (wr_ptr_q == 1'(b))) bank_d[b] = wr_last ? FULL : FILLING;
      if (rd_en && !iss_act_q && (iss_ptr_q == 1'(b))) bank_d[b] = DRAINING;
      if (drain_done && (rd_ptr_q == 1'(b))) bank_d[b] = EMPTY;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wr_r_d   = wr_r_q;
    wr_c_d   = wr_c_q;
    if (wr_fire) begin
      if (wr_last) begin
        wr_r_d   = 9'd0;
        wr_c_d   = 8'd0;
        wr_ptr_d = !wr_ptr_q;
      end else if (wr_c_q == n2_q - 8'd1) begin
        wr_c_d = 8'd0;
        wr_r_d = wr_r_q + 9'd1;
      end else begin
        wr_c_d = wr_c_q + 8'd1;
      end
    end
  end

  // Issue pointer runs ahead of the drain pointer so a waiting FULL bank
  // starts reading right after the previous bank's last read, without a bubble.
  always_comb begin
    iss_ptr_d = iss_ptr_q;
    iss_act_d = iss_act_q;
    iss_r_d   = iss_r_q;
    iss_c_d   = iss_c_q;
    rd_ptr_d  = drain_done ? !rd_ptr_q : rd_ptr_q;
    if (rd_en) begin
      iss_act_d = !iss_last;
      if (iss_last) begin
        iss_r_d   = 9'd0;
        iss_c_d   = 8'd0;
        iss_ptr_d = !iss_ptr_q;
      end else if (iss_r_q == n1_q - 9'd1) begin
        iss_r_d = 9'd0;
        iss_c_d = iss_c_q + 8'd1;
      end else begin
        iss_r_d = iss_r_q + 9'd1;
      end
    end
  end

  always_comb begin
    s1_valid_d  = rd_en ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    s1_last_d   = rd_en ? iss_last : s1_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_re_d = rd_re_q;
        out_im_d = rd_im_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_re[wr_addr] <= in_re;
      mem_im[wr_addr] <= in_im;
    end
    if (rd_en) begin
      rd_re_q <= mem_re[rd_addr];
      rd_im_q <= mem_im[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      n1_q        <= 9'd1;
      n2_q        <= 8'd1;
      cfg_err_q   <= 1'b0;
      wr_ptr_q    <= 1'b0;
      wr_r_q      <= 9'd0;
      wr_c_q      <= 8'd0;
      iss_ptr_q   <= 1'b0;
      iss_act_q   <= 1'b0;
      iss_r_q     <= 9'd0;
      iss_c_q     <= 8'd0;
      rd_ptr_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      n1_q        <= n1_d;
      n2_q        <= n2_d;
      cfg_err_q   <= cfg_err_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_r_q      <= wr_r_d;
      wr_c_q      <= wr_c_d;
      iss_ptr_q   <= iss_ptr_d;
      iss_act_q   <= iss_act_d;
      iss_r_q     <= iss_r_d;
      iss_c_q     <= iss_c_d;
      rd_ptr_q    <= rd_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule
`default_nettype wire
